// File: rtl/elevator_pkg.sv
// ============================================================================
// Module   : elevator_pkg
// Purpose  : Shared types and sizing helpers for the elevator call path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

    localparam int NUM_FLOORS_DEFAULT = 4;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        OFFER = 2'd2
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int floor_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/toggle_call_decoder_if.sv
// ============================================================================
// Module   : toggle_call_decoder_if
// Purpose  : Request/serve handshake bundle between call decoder and controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface toggle_call_decoder_if #(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS_DEFAULT
);
    localparam int FLOOR_W = elevator_pkg::floor_w(NUM_FLOORS);

    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic                  req_ready;
    logic                  serve_valid;
    logic [FLOOR_W-1:0]    serve_floor;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        output req_valid, req_floor, pending,
        input  req_ready, serve_valid, serve_floor
    );

    modport slave (
        input  req_valid, req_floor, pending,
        output req_ready, serve_valid, serve_floor
    );

endinterface

`default_nettype wire

// File: rtl/toggle_sync_detect.sv
// ============================================================================
// Module   : toggle_sync_detect
// Purpose  : Synchronise one toggle line and pulse once per level change.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic toggle_i,
    input  wire logic en_i,
    output logic      event_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // prev keeps tracking while disabled so no stale edge fires on enable.
    assign event_o = en_i & (sync_q[SYNC_STAGES-1] ^ prev_q);

endmodule

`default_nettype wire

// File: rtl/toggle_call_decoder.sv
// ============================================================================
// Module   : toggle_call_decoder
// Purpose  : Turns toggle-signalled floor calls into round-robin handshake requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_call_decoder
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = NUM_FLOORS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic [NUM_FLOORS-1:0] toggle_in,
    toggle_call_decoder_if.master      bus
);

    localparam int FLOOR_W = floor_w(NUM_FLOORS);
    localparam int CNT_W   = floor_w(SYNC_STAGES + 1);

    state_t                state_q;
    logic [CNT_W-1:0]      init_cnt_q;
    logic                  req_valid_q;
    logic [FLOOR_W-1:0]    req_floor_q;
    logic [FLOOR_W-1:0]    last_grant_q;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] issued_q, issued_d;
    logic [NUM_FLOORS-1:0] event_w;
    logic [NUM_FLOORS-1:0] clear_w;
    logic [NUM_FLOORS-1:0] cand_w;
    logic                  det_en_w;
    logic                  handshake_w;
    logic                  sel_found_w;
    logic [FLOOR_W-1:0]    sel_floor_w;
    int                    rr_idx;

    assign det_en_w = (state_q != INIT);

    generate
        for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
            toggle_sync_detect #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_det (
                .clk      (clk),
                .reset_n  (reset_n),
                .toggle_i (toggle_in[i]),
                .en_i     (det_en_w),
                .event_o  (event_w[i])
            );
        end
    endgenerate

    assign handshake_w = req_valid_q & bus.req_ready;
    assign cand_w      = pending_q & ~issued_q;

    // Out-of-range serve_floor values simply match no bit.
    always_comb begin
        clear_w = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            clear_w[i] = bus.serve_valid && (bus.serve_floor == FLOOR_W'(i));
        end
    end

    always_comb begin
        issued_d = issued_q;
        if (handshake_w && pending_q[req_floor_q]) begin
            issued_d[req_floor_q] = 1'b1;
        end
        // A new event beats a same-cycle serve so the call is not lost.
        pending_d = (pending_q & ~clear_w) | event_w;
        issued_d  = issued_d & ~clear_w;
    end

    always_comb begin
        sel_found_w = 1'b0;
        sel_floor_w = '0;
        rr_idx      = 0;
        for (int k = 1; k <= NUM_FLOORS; k++) begin
            rr_idx = (int'(last_grant_q) + k) % NUM_FLOORS;
            if (!sel_found_w && cand_w[rr_idx]) begin
                sel_found_w = 1'b1;
                sel_floor_w = FLOOR_W'(rr_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            issued_q  <= '0;
        end else begin
            pending_q <= pending_d;
            issued_q  <= issued_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= INIT;
            init_cnt_q   <= '0;
            req_valid_q  <= 1'b0;
            req_floor_q  <= '0;
            last_grant_q <= FLOOR_W'(NUM_FLOORS - 1);
        end else begin
            case (state_q)
                INIT: begin
                    if (init_cnt_q == CNT_W'(SYNC_STAGES)) begin
                        state_q <= IDLE;
                    end else begin
                        init_cnt_q <= init_cnt_q + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (sel_found_w) begin
                        req_floor_q <= sel_floor_w;
                        req_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.req_ready) begin
                        req_valid_q  <= 1'b0;
                        last_grant_q <= req_floor_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.req_valid = req_valid_q;
    assign bus.req_floor = req_floor_q;
    assign bus.pending   = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_toggle_call_decoder.sv
// ============================================================================
// Module   : tb_toggle_call_decoder
// Purpose  : Self-checking bench: directed scenarios plus random traffic vs a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toggle_call_decoder;

    localparam int N = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] toggle_in;

    int n_checks = 0;
    int n_err    = 0;

    toggle_call_decoder_if #(.NUM_FLOORS(N)) bus ();

    toggle_call_decoder #(
        .NUM_FLOORS  (N),
        .SYNC_STAGES (S)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .toggle_in (toggle_in),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a flip sampled on edge k becomes a call on edge k+S,
    // unless that edge falls within the first S+1 edges after reset.
    logic [N-1:0] samp[$];
    int           edge_n;
    logic [N-1:0] m_pend, m_iss, m_evt, m_clr, m_hs, m_cand, m_a, m_b;
    logic         m_valid, m_found;
    logic [1:0]   m_floor, m_last;
    int           m_idx;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp.delete();
            edge_n  = 0;
            m_pend  = '0;
            m_iss   = '0;
            m_valid = 1'b0;
            m_floor = 2'd0;
            m_last  = 2'(N - 1);
        end else begin
            edge_n++;
            samp.push_back(toggle_in);
            m_a   = (edge_n - S >= 1)     ? samp[edge_n - S - 1] : '0;
            m_b   = (edge_n - S - 1 >= 1) ? samp[edge_n - S - 2] : '0;
            m_evt = (edge_n > S + 1) ? (m_a ^ m_b) : '0;
            m_clr = bus.serve_valid ? (N'(1) << bus.serve_floor) : '0;
            m_hs  = '0;
            if (m_valid) begin
                if (bus.req_ready) begin
                    m_valid = 1'b0;
                    m_last  = m_floor;
                    if (m_pend[m_floor]) m_hs[m_floor] = 1'b1;
                end
            end else if (edge_n > S + 1) begin
                m_cand  = m_pend & ~m_iss;
                m_found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    m_idx = (int'(m_last) + k) % N;
                    if (!m_found && m_cand[m_idx]) begin
                        m_found = 1'b1;
                        m_floor = 2'(m_idx);
                        m_valid = 1'b1;
                    end
                end
            end
            m_pend = (m_pend & ~m_clr) | m_evt;
            m_iss  = (m_iss | m_hs) & ~m_clr;
        end
        #1;
        chk("model_valid",   bus.req_valid, m_valid);
        chk("model_floor",   bus.req_floor, m_floor);
        chk("model_pending", bus.pending,   m_pend);
    end

    int q_cyc[$];
    int q_fl[$];
    int exp_rr[3] = '{0, 1, 3};
    int cnt1;

    initial begin
        reset_n         = 1'b0;
        toggle_in       = 4'b0100;
        bus.req_ready   = 1'b0;
        bus.serve_valid = 1'b0;
        bus.serve_floor = '0;

        // Reset state, then a line already high must not make a phantom call.
        repeat (3) @(negedge clk);
        chk("rst_valid",   bus.req_valid, 0);
        chk("rst_floor",   bus.req_floor, 0);
        chk("rst_pending", bus.pending,   0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("init_valid",   bus.req_valid, 0);
            chk("init_pending", bus.pending,   0);
        end

        // Single call on floor 2 with a stalled controller.
        toggle_in[2] = ~toggle_in[2];
        repeat (3) @(negedge clk);
        chk("f2_pending", bus.pending,   4'b0100);
        chk("f2_early",   bus.req_valid, 0);
        @(negedge clk);
        chk("f2_valid", bus.req_valid, 1);
        chk("f2_floor", bus.req_floor, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("f2_hold_valid", bus.req_valid, 1);
            chk("f2_hold_floor", bus.req_floor, 2);
        end
        bus.req_ready = 1'b1;
        @(negedge clk);
        chk("f2_accepted", bus.req_valid, 0);
        bus.req_ready   = 1'b0;
        bus.serve_valid = 1'b1;
        bus.serve_floor = 2'd2;
        @(negedge clk);
        bus.serve_valid = 1'b0;
        chk("f2_served", bus.pending, 0);
        repeat (3) @(negedge clk);
        chk("f2_no_reoffer", bus.req_valid, 0);

        // Fresh reset so round-robin starts after floor 3.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        toggle_in = 4'b0000;
        repeat (5) @(negedge clk);
        bus.req_ready = 1'b1;
        toggle_in = 4'b1011;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.req_valid) begin
                q_cyc.push_back(i);
                q_fl.push_back(int'(bus.req_floor));
            end
        end
        chk("rr_count", q_fl.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk("rr_floor", (k < q_fl.size()) ? q_fl[k] : 99, exp_rr[k]);
        end
        chk("rr_gap01", (q_cyc.size() >= 3) ? q_cyc[1] - q_cyc[0] : 0, 2);
        chk("rr_gap12", (q_cyc.size() >= 3) ? q_cyc[2] - q_cyc[1] : 0, 2);
        chk("rr_pending", bus.pending, 4'b1011);
        foreach (exp_rr[k]) begin
            bus.serve_valid = 1'b1;
            bus.serve_floor = 2'(exp_rr[k]);
            @(negedge clk);
        end
        bus.serve_valid = 1'b0;
        chk("rr_served", bus.pending, 0);

        // Two flips on floor 1 before service merge into a single request.
        cnt1 = 0;
        toggle_in[1] = ~toggle_in[1];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req_valid && bus.req_floor == 2'd1) cnt1++;
        end
        toggle_in[1] = ~toggle_in[1];
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.req_valid) cnt1++;
        end
        chk("merge_count",   cnt1, 1);
        chk("merge_pending", bus.pending, 4'b0010);
        bus.serve_valid = 1'b1;
        bus.serve_floor = 2'd1;
        @(negedge clk);
        bus.serve_valid = 1'b0;
        chk("merge_served", bus.pending, 0);

        // New call on floor 3 lands on the same edge as its serve: set wins.
        toggle_in[3] = ~toggle_in[3];
        repeat (8) @(negedge clk);
        bus.req_ready = 1'b0;
        toggle_in[3]  = ~toggle_in[3];
        repeat (2) @(negedge clk);
        bus.serve_valid = 1'b1;
        bus.serve_floor = 2'd3;
        @(negedge clk);
        bus.serve_valid = 1'b0;
        chk("setwin_pending", bus.pending, 4'b1000);
        @(negedge clk);
        chk("setwin_valid", bus.req_valid, 1);
        chk("setwin_floor", bus.req_floor, 3);
        bus.req_ready = 1'b1;
        @(negedge clk);
        bus.req_ready   = 1'b0;
        bus.serve_valid = 1'b1;
        bus.serve_floor = 2'd3;
        @(negedge clk);
        bus.serve_valid = 1'b0;
        chk("setwin_served", bus.pending, 0);

        // Asynchronous reset in the middle of an offer.
        toggle_in[1] = ~toggle_in[1];
        repeat (4) @(negedge clk);
        chk("arst_pre_valid", bus.req_valid, 1);
        chk("arst_pre_floor", bus.req_floor, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid",   bus.req_valid, 0);
        chk("arst_pending", bus.pending,   0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("arst_init_valid", bus.req_valid, 0);
            chk("arst_init_pend",  bus.pending,   0);
        end

        // Random traffic against the model, with one asynchronous reset.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) toggle_in[b] = ~toggle_in[b];
            end
            bus.req_ready   = 1'($urandom_range(0, 1));
            bus.serve_valid = ($urandom_range(0, 3) == 0);
            bus.serve_floor = 2'($urandom_range(0, N - 1));
            if (i == 400) begin
                #($urandom_range(1, 3));
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
        bus.serve_valid = 1'b0;
        bus.req_ready   = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
